// File: rtl/apb_uart_seq_if.sv
// ----------------------------------------------------------------------------
// apb_uart_seq_if
// APB3 bus bundle between the UART sequencer (master) and the UART register
// slave.
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave -> master
// ----------------------------------------------------------------------------
interface apb_uart_seq_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_seq.sv
// ----------------------------------------------------------------------------
// apb_uart_seq
// APB master that owns a UART register block (DATA 0x0, CTRL 0x4, STAT 0x8,
// INT 0xC). On cfg_start it writes CTRL once, then polls STAT and moves bytes
// between a TX stream (written to DATA) and an RX stream (read from DATA,
// followed by a W1C clear of INT), alternating when both are serviceable.
//
// Ports:
//   PCLK, PRESET         clock, asynchronous active-high reset
//   cfg_start            1-cycle pulse, (re)starts from IDLE/HALT, clears err
//   tx_data/tx_valid     TX byte in; tx_ready is a 1-cycle accept strobe
//   rx_data/rx_valid     RX byte out, held until rx_ready
//   apb                  APB master port (apb_uart_seq_if.master)
//   busy                 sequencer is neither IDLE nor HALT
//   err                  sticky PSLVERR (or watchdog timeout) flag
//
// Build option: APB_UART_SEQ_TIMEOUT_EN adds an 8-bit ACCESS watchdog that
// abandons a transfer after 255 cycles without PREADY and halts with err=1.
// ----------------------------------------------------------------------------
module apb_uart_seq #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CTRL_VAL   = 8'h83,
    parameter int                    POLL_GAP   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cfg_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    apb_uart_seq_if.master        apb,
    output logic                  busy,
    output logic                  err
);
    localparam logic [ADDR_WIDTH-1:0] A_DATA = ADDR_WIDTH'(4'h0);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(4'h4);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(4'h8);
    localparam logic [ADDR_WIDTH-1:0] A_INT  = ADDR_WIDTH'(4'hC);
    // Clears only rx_done in INT; other interrupt bits are left alone.
    localparam logic [DATA_WIDTH-1:0] INT_CLR = DATA_WIDTH'(8'h02);
    localparam int                    GAP_W   = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_POLL, S_DECIDE, S_TX_WR, S_RX_RD, S_RX_CLR, S_GAP, S_HALT
    } state_e;

    // APB phase within a transfer state; PH_IDLE doubles as the mandatory
    // PSEL=0 cycle between back-to-back transfers.
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_e;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] stat_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_ready_q;
    logic                  last_tx_q;   // 1: TX served last (reset so RX goes first)
    logic                  err_q;

    logic xfer_done, xfer_ok, timeout, idle_like;
    logic rx_elig, tx_elig, pick_rx;

    assign xfer_done = (phase_q == PH_ACCESS) && apb.PREADY;
    assign xfer_ok   = xfer_done && !apb.PSLVERR;
    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

    assign rx_elig = !stat_q[0] && !rx_valid_q;
    assign tx_elig = tx_valid && !stat_q[4];
    assign pick_rx = rx_elig && (!tx_elig || last_tx_q);

    // Only rx_empty and tx_full steer the sequencer.
    logic unused_stat;
    assign unused_stat = ^{stat_q[DATA_WIDTH-1:5], stat_q[3:1]};

`ifdef APB_UART_SEQ_TIMEOUT_EN
    logic [7:0] wd_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)                                  wd_q <= '0;
        else if (phase_q == PH_ACCESS && !apb.PREADY) wd_q <= wd_q + 8'd1;
        else                                         wd_q <= '0;
    end

    // Fires on the 255th ACCESS cycle that still has no PREADY.
    assign timeout = (phase_q == PH_ACCESS) && !apb.PREADY && (wd_q == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gap_cnt_d = '0;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (cfg_start) begin
                    state_d = S_CFG;
                    phase_d = PH_SETUP;
                end
            end
            S_CFG, S_POLL, S_TX_WR, S_RX_RD, S_RX_CLR: begin
                case (phase_q)
                    PH_IDLE:  phase_d = PH_SETUP;
                    PH_SETUP: phase_d = PH_ACCESS;
                    default: begin
                        if (xfer_done) begin
                            phase_d = PH_IDLE;
                            if (apb.PSLVERR) begin
                                state_d = S_HALT;
                            end else begin
                                case (state_q)
                                    S_CFG:   state_d = S_POLL;
                                    S_POLL:  state_d = S_DECIDE;
                                    S_RX_RD: state_d = S_RX_CLR;
                                    default: state_d = S_POLL;
                                endcase
                            end
                        end else if (timeout) begin
                            phase_d = PH_IDLE;
                            state_d = S_HALT;
                        end
                    end
                endcase
            end
            // DECIDE is itself a PSEL=0 cycle, so the chosen transfer
            // starts straight in SETUP.
            S_DECIDE: begin
                if (pick_rx) begin
                    state_d = S_RX_RD;
                    phase_d = PH_SETUP;
                end else if (tx_elig) begin
                    state_d = S_TX_WR;
                    phase_d = PH_SETUP;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = S_POLL;
                    phase_d = PH_SETUP;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = PH_IDLE;
            end
        endcase

        // Write data is captured on entry to SETUP and held through ACCESS,
        // so tx_data only has to be stable up to that point.
        if (phase_d == PH_SETUP) begin
            case (state_d)
                S_CFG:    wdata_d = CTRL_VAL;
                S_TX_WR:  wdata_d = tx_data;
                S_RX_CLR: wdata_d = INT_CLR;
                default:  wdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_IDLE;
            gap_cnt_q  <= '0;
            wdata_q    <= '0;
            stat_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            last_tx_q  <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gap_cnt_q  <= gap_cnt_d;
            wdata_q    <= wdata_d;
            tx_ready_q <= xfer_ok && (state_q == S_TX_WR);

            if (xfer_ok) begin
                case (state_q)
                    S_POLL:   stat_q    <= apb.PRDATA;
                    S_TX_WR:  last_tx_q <= 1'b1;
                    S_RX_RD:  rx_data_q <= apb.PRDATA;
                    S_RX_CLR: last_tx_q <= 1'b0;
                    default: ;
                endcase
            end

            // RX_RD is only entered with the buffer empty, so set and clear
            // never collide.
            if (rx_valid_q && rx_ready)                rx_valid_q <= 1'b0;
            else if (xfer_ok && state_q == S_RX_RD)    rx_valid_q <= 1'b1;

            if (idle_like && cfg_start)                      err_q <= 1'b0;
            else if ((xfer_done && apb.PSLVERR) || timeout)  err_q <= 1'b1;
        end
    end

    always_comb begin
        apb.PSEL    = (phase_q != PH_IDLE);
        apb.PENABLE = (phase_q == PH_ACCESS);
        apb.PADDR   = '0;
        apb.PWRITE  = 1'b0;
        if (phase_q != PH_IDLE) begin
            case (state_q)
                S_CFG:    begin apb.PADDR = A_CTRL; apb.PWRITE = 1'b1; end
                S_POLL:   begin apb.PADDR = A_STAT; apb.PWRITE = 1'b0; end
                S_TX_WR:  begin apb.PADDR = A_DATA; apb.PWRITE = 1'b1; end
                S_RX_CLR: begin apb.PADDR = A_INT;  apb.PWRITE = 1'b1; end
                default:  begin apb.PADDR = A_DATA; apb.PWRITE = 1'b0; end
            endcase
        end
    end

    assign apb.PWDATA = wdata_q;
    assign tx_ready   = tx_ready_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = !idle_like;
    assign err        = err_q;
endmodule

// File: tb/tb_apb_uart_seq.sv
`timescale 1ns/1ps
module tb_apb_uart_seq;
    localparam int POLL_GAP = 16;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cfg_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       busy, err;

    apb_uart_seq_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) apb();

    apb_uart_seq #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CTRL_VAL(8'h83), .POLL_GAP(POLL_GAP)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .cfg_start(cfg_start),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .apb(apb), .busy(busy), .err(err)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- UART register slave model (loopback) ----------------
    int         wait_n = 0;
    logic       hang = 1'b0;
    logic       err_en = 1'b0;
    logic [3:0] err_addr = 4'h4;
    logic       stat_force_en = 1'b0;
    logic [7:0] stat_force = 8'h00;
    logic [7:0] fifo [0:15];
    logic [4:0] wp, rp;
    int         wcnt;
    logic [7:0] stat_live;

    assign stat_live   = stat_force_en ? stat_force : {7'b0, (wp == rp)};
    assign apb.PREADY  = apb.PSEL && apb.PENABLE && !hang && (wcnt >= wait_n);
    assign apb.PSLVERR = apb.PREADY && err_en && (apb.PADDR == err_addr);
    assign apb.PRDATA  = !apb.PSEL ? 8'h00 :
                         (apb.PADDR == 4'h8) ? stat_live :
                         (apb.PADDR == 4'h0) ? fifo[rp[3:0]] : 8'h00;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wp <= '0; rp <= '0; wcnt <= 0;
        end else if (apb.PSEL && apb.PENABLE) begin
            if (apb.PREADY) begin
                wcnt <= 0;
                if (apb.PADDR == 4'h0 && apb.PWRITE) begin
                    fifo[wp[3:0]] <= apb.PWDATA;
                    wp <= wp + 5'd1;
                end
                if (apb.PADDR == 4'h0 && !apb.PWRITE && wp != rp) rp <= rp + 5'd1;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_xfer[$];
    logic [7:0]  exp_rx[$];
    int          tx_acc = 0;
    logic [31:0] mon_act;

    function automatic logic [31:0] xf(input logic w, input logic [3:0] a, input logic [7:0] d);
        return {19'b0, w, a, d};
    endfunction

    // STAT polls are not scored; every other completed transfer must match
    // the next expected entry.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PADDR != 4'h8) begin
                mon_act = xf(apb.PWRITE, apb.PADDR, apb.PWRITE ? apb.PWDATA : 8'h00);
                if (exp_xfer.size() == 0) chk("xfer_unexpected", mon_act, 32'hFFFF_FFFF);
                else                      chk("xfer", mon_act, exp_xfer.pop_front());
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", {24'b0, rx_data}, 32'hFFFF_FFFF);
                else                    chk("rx_data", {24'b0, rx_data}, {24'b0, exp_rx.pop_front()});
            end
            if (tx_ready) tx_acc++;
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        @(negedge PCLK);
        cfg_start = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (tx_ready) break;
        end
        chk(tag, tx_ready, 1);
    endtask

    task automatic wait_xfer_drain(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (exp_xfer.size() == 0) break;
            @(negedge PCLK);
        end
        chk(tag, exp_xfer.size(), 0);
    endtask

    task automatic wait_stat_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PADDR == 4'h8) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic ok;

        // 1: reset state, CFG write timing, first STAT poll
        cyc(2);
        chk("rst_apb", {apb.PSEL, apb.PENABLE}, 0);
        chk("rst_flags", {busy, err, tx_ready, rx_valid}, 0);
        PRESET = 1'b0;
        cyc(1);
        wait_n = 2;
        exp_xfer.push_back(xf(1, 4'h4, 8'h83));
        pulse_start();
        chk("cfg_setup", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 3'b101);
        chk("cfg_addr", apb.PADDR, 4'h4);
        chk("cfg_wdata", apb.PWDATA, 8'h83);
        chk("cfg_busy", busy, 1);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE) begin
                n++;
                chk("cfg_access_hold", {apb.PADDR, apb.PWDATA}, {4'h4, 8'h83});
            end
            if (apb.PREADY) break;
        end
        chk("cfg_access_cycles", n, 3);
        @(negedge PCLK);
        chk("idle_between", apb.PSEL, 0);
        @(negedge PCLK);
        chk("poll_setup", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR}, {3'b100, 4'h8});
        wait_n = 0;

        // 2: loopback TX then RX then INT clear
        rx_ready = 1'b1;
        exp_xfer.push_back(xf(1, 4'h0, 8'h55));
        exp_xfer.push_back(xf(0, 4'h0, 8'h00));
        exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_rx.push_back(8'h55);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        wait_tx("t2_tx_ready");
        tx_valid = 1'b0;
        wait_xfer_drain("t2_drain");
        cyc(3);
        chk("t2_rx_left", exp_rx.size(), 0);
        chk("t2_tx_count", tx_acc, 1);

        // 3: tx_full (rx_empty also set so RX is not eligible) -> GAP
        stat_force = 8'h11;
        stat_force_en = 1'b1;
        wait_stat_done("t3_poll0");
        wait_stat_done("t3_poll1");
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (apb.PSEL) break;
            n++;
        end
        // DECIDE cycle plus POLL_GAP GAP cycles
        chk("t3_gap_idle", n, POLL_GAP + 1);
        chk("t3_no_tx", tx_acc, 1);
        stat_force = 8'h01;
        exp_xfer.push_back(xf(1, 4'h0, 8'hA5));
        wait_tx("t3_tx_ready");

        // 4: both eligible -> alternate, RX first (last served was TX)
        stat_force = 8'h00;
        tx_data = 8'h11;
        exp_xfer.push_back(xf(0, 4'h0, 8'h00)); exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_xfer.push_back(xf(1, 4'h0, 8'h11));
        exp_xfer.push_back(xf(0, 4'h0, 8'h00)); exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_xfer.push_back(xf(1, 4'h0, 8'h22));
        exp_xfer.push_back(xf(0, 4'h0, 8'h00)); exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_xfer.push_back(xf(1, 4'h0, 8'h33));
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h11); exp_rx.push_back(8'h22);
        wait_tx("t4_tx11");
        tx_data = 8'h22;
        wait_tx("t4_tx22");
        tx_data = 8'h33;
        wait_tx("t4_tx33");
        // consumer stalls: one RX fetch, then TX only
        rx_ready = 1'b0;
        tx_data = 8'h44;
        exp_xfer.push_back(xf(0, 4'h0, 8'h00)); exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_xfer.push_back(xf(1, 4'h0, 8'h44));
        exp_xfer.push_back(xf(1, 4'h0, 8'h55));
        exp_xfer.push_back(xf(1, 4'h0, 8'h66));
        exp_rx.push_back(8'h33);
        wait_tx("t4_tx44");
        tx_data = 8'h55;
        wait_tx("t4_tx55");
        tx_data = 8'h66;
        wait_tx("t4_tx66");
        tx_valid = 1'b0;
        stat_force = 8'h01;
        wait_xfer_drain("t4_drain");
        chk("t4_rx_held", rx_valid, 1);
        chk("t4_rx_held_data", rx_data, 8'h33);
        rx_ready = 1'b1;
        cyc(2);
        chk("t4_rx_left", exp_rx.size(), 0);

        // 5: PSLVERR on CTRL write -> HALT; restart clears err
        PRESET = 1'b1;
        cyc(1);
        PRESET = 1'b0;
        stat_force_en = 1'b0;
        err_en = 1'b1;
        exp_xfer.push_back(xf(1, 4'h4, 8'h83));
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (err) begin ok = 1'b1; break; end
        end
        chk("t5_err", ok, 1);
        chk("t5_busy", busy, 0);
        n = 0;
        repeat (20) begin
            @(negedge PCLK);
            if (apb.PSEL) n++;
        end
        chk("t5_no_psel", n, 0);
        chk("t5_err_sticky", err, 1);
        err_en = 1'b0;
        exp_xfer.push_back(xf(1, 4'h4, 8'h83));
        pulse_start();
        chk("t5_err_clr", err, 0);
        chk("t5_busy_again", busy, 1);
        wait_xfer_drain("t5_cfg_replay");

        // 6: reset in the middle of an ACCESS phase
        rx_ready = 1'b0;
        exp_xfer.push_back(xf(1, 4'h0, 8'h3C));
        exp_xfer.push_back(xf(0, 4'h0, 8'h00));
        exp_xfer.push_back(xf(1, 4'hC, 8'h02));
        exp_rx.push_back(8'h3C);
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        wait_tx("t6_tx_ready");
        tx_valid = 1'b0;
        wait_xfer_drain("t6_drain");
        chk("t6_rx_held", rx_valid, 1);
        hang = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE) begin ok = 1'b1; break; end
        end
        chk("t6_in_access", ok, 1);
        #2 PRESET = 1'b1;
        #1;
        chk("t6_rst_apb", {apb.PSEL, apb.PENABLE}, 0);
        chk("t6_rst_strobes", {tx_ready, rx_valid}, 0);
        chk("t6_rst_busy", busy, 0);
        exp_rx.delete();
        @(negedge PCLK);
        PRESET = 1'b0;

`ifdef APB_UART_SEQ_TIMEOUT_EN
        // watchdog: PREADY never comes
        cyc(1);
        pulse_start();
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE) n++;
            else if (n > 0) break;
        end
        chk("to_access_cycles", n, 255);
        chk("to_err", err, 1);
        chk("to_busy", busy, 0);
        exp_xfer.delete();
`endif
        hang = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
